// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port (fetch/data) memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    localparam logic SEL_FETCH = 1'b0;
    localparam logic SEL_DATA  = 1'b1;

    localparam int CNT_W = 4;

endpackage

// File: rtl/arb_wait_counter.sv
// Loadable 4-bit down-counter; tc flags that the current ACCESS cycle is the last one.
module arb_wait_counter
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (dec && (cnt_q != '0))
            cnt_d = cnt_q - 4'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one memory with WAIT_CYCLES wait states.
// Define ARB_ROUND_ROBIN_EN for alternating contested grants; otherwise data always wins.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int SIZE        = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_req,
    input  logic [SIZE-1:0] i_addr,
    output logic            i_done,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [SIZE-1:0] d_addr,
    input  logic [SIZE-1:0] d_wdata,
    output logic            d_done,
    output logic [SIZE-1:0] rdata,
    output logic            mem_sel,
    output logic            mem_en,
    output logic            mem_we,
    output logic [SIZE-1:0] mem_addr,
    output logic [SIZE-1:0] mem_wdata,
    input  logic [SIZE-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

    arb_state_e      state_q, state_d;
    logic            sel_q, sel_d;
    logic            we_q, we_d;
    logic [SIZE-1:0] addr_q, addr_d;
    logic [SIZE-1:0] wdata_q, wdata_d;
    logic [SIZE-1:0] rdata_q, rdata_d;
    logic            grant_data;
    logic            cnt_load, cnt_dec, cnt_tc;

`ifdef ARB_ROUND_ROBIN_EN
    logic            last_q, last_d;
`endif

    always_comb begin
        grant_data = 1'b0;
        if (d_req && !i_req)
            grant_data = 1'b1;
        else if (i_req && !d_req)
            grant_data = 1'b0;
        else if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant_data = (last_q == SEL_FETCH);
`else
            grant_data = 1'b1;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_d   = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    cnt_load = 1'b1;
                    state_d  = ACCESS;
                    if (grant_data) begin
                        sel_d   = SEL_DATA;
                        we_d    = d_we;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                    end else begin
                        sel_d   = SEL_FETCH;
                        we_d    = 1'b0;
                        addr_d  = i_addr;
                        wdata_d = '0;
                    end
`ifdef ARB_ROUND_ROBIN_EN
                    last_d = grant_data ? SEL_DATA : SEL_FETCH;
`endif
                end
            end
            ACCESS: begin
                cnt_dec = 1'b1;
                if (cnt_tc) begin
                    rdata_d = mem_rdata;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= SEL_FETCH;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Starts at fetch so the first contested grant after reset goes to data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) last_q <= SEL_FETCH;
        else       last_q <= last_d;
    end
`endif

    arb_wait_counter u_wait (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (WAIT_LD),
        .dec      (cnt_dec),
        .tc       (cnt_tc)
    );

    // Outputs decode straight from flops so reset clears them without waiting for an edge.
    assign mem_en    = (state_q == ACCESS);
    assign mem_we    = mem_en && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_sel   = sel_q;
    assign rdata     = rdata_q;
    assign i_done    = (state_q == RESP) && (sel_q == SEL_FETCH);
    assign d_done    = (state_q == RESP) && (sel_q == SEL_DATA);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: u0 runs with one wait state, u1 with zero wait states.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cyc = '0;
    logic [31:0] mem_rdata;
    int          n_asrt = 0;
    int          n_fail = 0;
    logic [31:0] exp_rd;
    logic        exp_sel;

    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_done, d_done, mem_sel, mem_en, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;

    logic        i_req1;
    logic [31:0] i_addr1;
    logic        i_done1, d_done1, mem_sel1, mem_en1, mem_we1;
    logic [31:0] rdata1, mem_addr1, mem_wdata1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 16'd1;
    assign mem_rdata = {16'hC0DE, cyc};

    mem_port_arbiter #(.SIZE(32), .WAIT_CYCLES(1)) u0 (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done),
        .rdata(rdata), .mem_sel(mem_sel), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.SIZE(32), .WAIT_CYCLES(0)) u1 (
        .clk(clk), .reset(reset),
        .i_req(i_req1), .i_addr(i_addr1), .i_done(i_done1),
        .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0), .d_done(d_done1),
        .rdata(rdata1), .mem_sel(mem_sel1), .mem_en(mem_en1), .mem_we(mem_we1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        i_req = 0; d_req = 0; d_we = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        i_req1 = 0; i_addr1 = '0;
        #1;
        chk("rst_mem_en",   {31'd0, mem_en},  32'd0);
        chk("rst_mem_we",   {31'd0, mem_we},  32'd0);
        chk("rst_mem_sel",  {31'd0, mem_sel}, 32'd0);
        chk("rst_done",     {30'd0, i_done, d_done}, 32'd0);
        chk("rst_rdata",    rdata,    32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        tick(); tick();
        reset = 1'b0;

        // Contention: both held; fixed priority gives data every time, round robin alternates.
        i_req = 1; i_addr = 32'h200;
        d_req = 1; d_we = 0; d_addr = 32'h300;
        for (int g = 0; g < 4; g++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_sel = (g % 2 == 0);
`else
            exp_sel = 1'b1;
`endif
            tick();
            chk("cont_sel",  {31'd0, mem_sel}, {31'd0, exp_sel});
            chk("cont_addr", mem_addr, exp_sel ? 32'h300 : 32'h200);
            tick();
            chk("cont_en2",  {31'd0, mem_en}, 32'd1);
            tick();
            chk("cont_d_done", {31'd0, d_done}, {31'd0, exp_sel});
            chk("cont_i_done", {31'd0, i_done}, {31'd0, ~exp_sel});
            tick();
            chk("cont_idle_en", {31'd0, mem_en}, 32'd0);
        end
        i_req = 0; d_req = 0;
        tick(); tick();

        // Single fetch
        i_req = 1; i_addr = 32'h0000_0040;
        tick();
        chk("f_c1_en",   {31'd0, mem_en},  32'd1);
        chk("f_c1_addr", mem_addr,         32'h40);
        chk("f_c1_sel",  {31'd0, mem_sel}, 32'd0);
        chk("f_c1_we",   {31'd0, mem_we},  32'd0);
        chk("f_c1_done", {31'd0, i_done},  32'd0);
        tick();
        chk("f_c2_en",   {31'd0, mem_en},  32'd1);
        chk("f_c2_addr", mem_addr,         32'h40);
        tick();
        exp_rd = {16'hC0DE, cyc - 16'd1};
        chk("f_c3_i_done", {31'd0, i_done}, 32'd1);
        chk("f_c3_d_done", {31'd0, d_done}, 32'd0);
        chk("f_c3_en",     {31'd0, mem_en}, 32'd0);
        chk("f_c3_rdata",  rdata, exp_rd);
        i_req = 0;
        tick();
        chk("f_c4_done", {31'd0, i_done}, 32'd0);
        chk("f_c4_en",   {31'd0, mem_en}, 32'd0);
        tick();

        // Store
        d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
        for (int c = 1; c <= 2; c++) begin
            tick();
            chk("st_we",    {31'd0, mem_we},  32'd1);
            chk("st_wdata", mem_wdata,        32'hDEADBEEF);
            chk("st_addr",  mem_addr,         32'h100);
            chk("st_sel",   {31'd0, mem_sel}, 32'd1);
            chk("st_i_done", {31'd0, i_done}, 32'd0);
        end
        tick();
        chk("st_d_done", {31'd0, d_done}, 32'd1);
        chk("st_i_done3", {31'd0, i_done}, 32'd0);
        chk("st_we_resp", {31'd0, mem_we}, 32'd0);
        d_req = 0; d_we = 0;
        tick();
        chk("st_d_done_off", {31'd0, d_done}, 32'd0);
        tick();

        // Reset in the middle of a data load
        d_req = 1; d_we = 0; d_addr = 32'h400;
        tick();
        chk("rm_en_pre", {31'd0, mem_en}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rm_en_async", {31'd0, mem_en}, 32'd0);
        chk("rm_we_async", {31'd0, mem_we}, 32'd0);
        tick();
        chk("rm_no_done", {31'd0, d_done}, 32'd0);
        chk("rm_en_hold", {31'd0, mem_en}, 32'd0);
        reset = 1'b0;
        tick();
        chk("rm_re_en",   {31'd0, mem_en}, 32'd1);
        chk("rm_re_sel",  {31'd0, mem_sel}, 32'd1);
        chk("rm_re_addr", mem_addr, 32'h400);
        tick();
        chk("rm_re_done_early", {31'd0, d_done}, 32'd0);
        tick();
        exp_rd = {16'hC0DE, cyc - 16'd1};
        chk("rm_re_done",  {31'd0, d_done}, 32'd1);
        chk("rm_re_rdata", rdata, exp_rd);
        d_req = 0;
        tick();

        // Zero wait states, fetch held: done every third cycle
        i_req1 = 1; i_addr1 = 32'h80;
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk("w0_i_done", {31'd0, i_done1}, {31'd0, (k % 3 == 2)});
            chk("w0_en",     {31'd0, mem_en1}, {31'd0, (k % 3 == 1)});
            if (k % 3 == 2) begin
                exp_rd = {16'hC0DE, cyc - 16'd1};
                chk("w0_rdata", rdata1, exp_rd);
            end
        end
        i_req1 = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
